// File: rtl/lcd_hex_driver.sv
// HD44780 8-bit write-only driver that shows two 32-bit words as hex on a 16x2 LCD.
// Power-up delay, four-command init, then continuous 34-transfer refresh frames.
module lcd_hex_driver #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned EN_CYC      = 25,
    parameter int unsigned CMD_CYC     = 2000,
    parameter int unsigned CLEAR_CYC   = 82000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] line1,
    input  logic [31:0] line2,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        ready,
    output logic        frame_done
);

    localparam int unsigned Max1   = (POWERUP_CYC > CLEAR_CYC) ? POWERUP_CYC : CLEAR_CYC;
    localparam int unsigned Max2   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int unsigned Max3   = (Max1 > Max2) ? Max1 : Max2;
    localparam int unsigned MaxCyc = (Max3 > SETUP_CYC) ? Max3 : SETUP_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] PowerupLast = CntW'(POWERUP_CYC - 1);
    localparam logic [CntW-1:0] SetupLast   = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] EnLast      = CntW'(EN_CYC - 1);
    localparam logic [CntW-1:0] CmdLast     = CntW'(CMD_CYC - 1);
    localparam logic [CntW-1:0] ClearLast   = CntW'(CLEAR_CYC - 1);

    typedef enum logic [1:0] {StPowerup, StInit, StRefresh} state_e;
    typedef enum logic [1:0] {PhSetup, PhPulse, PhWait} phase_e;

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [31:0]     snap1_q, snap1_d, snap2_q, snap2_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d, en_q, en_d, ready_q, ready_d, frame_q, frame_d;
    logic            load;
    logic [CntW-1:0] wait_last;

    // Returns {rs, byte} for transfer idx of the init sequence or of a refresh frame.
    function automatic logic [8:0] xfer_byte(state_e st, logic [5:0] idx,
                                             logic [31:0] w1, logic [31:0] w2);
        logic [3:0]  pos;
        logic [31:0] word;
        logic [3:0]  nib;
        xfer_byte = 9'h000;
        pos       = '0;
        word      = '0;
        nib       = '0;
        if (st == StInit) begin
            unique case (idx[1:0])
                2'd0:    xfer_byte = {1'b0, 8'h38};
                2'd1:    xfer_byte = {1'b0, 8'h0C};
                2'd2:    xfer_byte = {1'b0, 8'h01};
                default: xfer_byte = {1'b0, 8'h06};
            endcase
        end else if (idx == 6'd0) begin
            xfer_byte = {1'b0, 8'h80};
        end else if (idx == 6'd17) begin
            xfer_byte = {1'b0, 8'hC0};
        end else begin
            pos  = (idx < 6'd17) ? 4'(idx - 6'd1) : 4'(idx - 6'd18);
            word = (idx < 6'd17) ? w1 : w2;
            nib  = 4'(word >> {~pos[2:0], 2'b00});
            if (pos[3]) begin
                xfer_byte = {1'b1, 8'h20};
            end else if (nib < 4'd10) begin
                xfer_byte = {1'b1, 8'h30 + {4'h0, nib}};
            end else begin
                xfer_byte = {1'b1, 8'h37 + {4'h0, nib}};
            end
        end
    endfunction

    // Clear is the only command needing the long post-strobe wait.
    assign wait_last = (data_q == 8'h01 && !rs_q) ? ClearLast : CmdLast;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        snap1_d = snap1_q;
        snap2_d = snap2_q;
        data_d  = data_q;
        rs_d    = rs_q;
        en_d    = en_q;
        ready_d = ready_q;
        frame_d = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            StPowerup: begin
                if (cnt_q == PowerupLast) begin
                    state_d = StInit;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            StInit, StRefresh: begin
                unique case (phase_q)
                    PhSetup: begin
                        if (cnt_q == SetupLast) begin
                            phase_d = PhPulse;
                            cnt_d   = '0;
                            en_d    = 1'b1;
                        end
                    end
                    PhPulse: begin
                        if (cnt_q == EnLast) begin
                            phase_d = PhWait;
                            cnt_d   = '0;
                            en_d    = 1'b0;
                        end
                    end
                    PhWait: begin
                        if (cnt_q == wait_last) begin
                            load = 1'b1;
                            if (state_q == StInit && idx_q == 6'd3) begin
                                state_d = StRefresh;
                                idx_d   = '0;
                                ready_d = 1'b1;
                            end else if (state_q == StRefresh && idx_q == 6'd33) begin
                                idx_d   = '0;
                                frame_d = 1'b1;
                            end else begin
                                idx_d = idx_q + 6'd1;
                            end
                        end
                    end
                    default: phase_d = PhSetup;
                endcase
            end
            default: state_d = StPowerup;
        endcase
        if (load) begin
            phase_d          = PhSetup;
            cnt_d            = '0;
            en_d             = 1'b0;
            {rs_d, data_d}   = xfer_byte(state_d, idx_d, snap1_q, snap2_q);
            // Both words are captured together as the frame's 0x80 transfer starts.
            if (state_d == StRefresh && idx_d == 6'd0) begin
                snap1_d = line1;
                snap2_d = line2;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StPowerup;
            phase_q <= PhSetup;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap1_q <= '0;
            snap2_q <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap1_q <= snap1_d;
            snap2_q <= snap2_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            frame_q <= frame_d;
        end
    end

    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = en_q;
    assign ready      = ready_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Bench for lcd_hex_driver: init timing, frame contents against a hex-text model,
// snapshot coherence, frame_done spacing and asynchronous reset mid-transfer.
module tb_lcd_hex_driver;

    logic        clock;
    logic        resetn;
    logic [31:0] line1, line2;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en, ready, frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rel   = 0;

    logic [7:0] rise_byte[$];
    logic       rise_rs[$];
    int         rise_cyc[$];
    int         fall_cyc[$];
    int         fd_cyc[$];
    int         ready_cyc[$];
    logic       en_prev = 1'b0;
    logic       ready_prev = 1'b0;
    logic       rw_bad = 1'b0;

    lcd_hex_driver #(
        .POWERUP_CYC(10),
        .SETUP_CYC  (1),
        .EN_CYC     (3),
        .CMD_CYC    (5),
        .CLEAR_CYC  (20)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .line1     (line1),
        .line2     (line2),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .ready     (ready),
        .frame_done(frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    // Bus monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (lcd_en && !en_prev) begin
            rise_byte.push_back(lcd_data);
            rise_rs.push_back(lcd_rs);
            rise_cyc.push_back(cyc);
        end
        if (!lcd_en && en_prev) fall_cyc.push_back(cyc);
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
        if (ready && !ready_prev) ready_cyc.push_back(cyc);
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        en_prev    = lcd_en;
        ready_prev = ready;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rise_byte.delete();
        rise_rs.delete();
        rise_cyc.delete();
        fall_cyc.delete();
        fd_cyc.delete();
        ready_cyc.delete();
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (rise_byte.size() < n && k < budget) begin
            @(posedge clock);
            k++;
        end
        check($sformatf("transfers_reached_%0d", n), 64'(rise_byte.size() >= n), 64'd1);
    endtask

    function automatic logic [7:0] hex_ch(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Expected {rs, byte} of transfer i (0..33) of a frame showing w1 / w2.
    function automatic logic [8:0] ref_xfer(input int i, input logic [31:0] w1,
                                            input logic [31:0] w2);
        longint unsigned w;
        longint unsigned p;
        int              c;
        if (i == 0) return {1'b0, 8'h80};
        if (i == 17) return {1'b0, 8'hC0};
        w = (i < 17) ? {32'd0, w1} : {32'd0, w2};
        c = (i < 17) ? i - 1 : i - 18;
        if (c >= 8) return {1'b1, 8'h20};
        p = 1;
        repeat (7 - c) p = p * 16;
        return {1'b1, hex_ch(int'((w / p) % 16))};
    endfunction

    task automatic check_frame(input int base, input logic [31:0] w1, input logic [31:0] w2,
                               input string tag);
        for (int i = 0; i < 34; i++) begin
            check($sformatf("%s_xfer%0d", tag, i), {55'd0, rise_rs[base+i], rise_byte[base+i]},
                  {55'd0, ref_xfer(i, w1, w2)});
        end
    endtask

    task automatic check_init(input string tag);
        int k = 0;
        wait_rises(5, 300);
        while (ready_cyc.size() == 0 && k < 300) begin
            @(posedge clock);
            k++;
        end
        check({tag, "_ready_seen"}, 64'(ready_cyc.size()), 64'd1);
        check({tag, "_first_rise"}, 64'(rise_cyc[0] - rel), 64'd11);
        check({tag, "_first_rs"}, 64'(rise_rs[0]), 64'd0);
        check({tag, "_en_width"}, 64'(fall_cyc[0] - rise_cyc[0]), 64'd3);
        check({tag, "_cmd0"}, 64'(rise_byte[0]), 64'h38);
        check({tag, "_cmd1"}, 64'(rise_byte[1]), 64'h0C);
        check({tag, "_cmd2"}, 64'(rise_byte[2]), 64'h01);
        check({tag, "_cmd3"}, 64'(rise_byte[3]), 64'h06);
        check({tag, "_clear_gap"}, 64'(rise_cyc[3] - fall_cyc[2]), 64'd21);
        check({tag, "_ready_rise"}, 64'(ready_cyc[0] - rel), 64'd61);
    endtask

    initial begin
        logic [31:0] w1, w2;
        int          fr;
        int          k;
        resetn = 1'b1;
        line1  = 32'hDEADBEEF;
        line2  = 32'h0123A5F9;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_data", 64'(lcd_data), 64'd0);
        check("rst_rs", 64'(lcd_rs), 64'd0);
        check("rst_rw", 64'(lcd_rw), 64'd0);
        check("rst_en", 64'(lcd_en), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        clear_log();
        resetn = 1'b1;
        rel    = cyc;
        check_init("init1");

        // Frame 1 occupies transfers 4..37; change line1 after frame 2's third character.
        wait_rises(4 + 34 + 4, 1000);
        check_frame(4, 32'hDEADBEEF, 32'h0123A5F9, "frame1");
        line1 = 32'h00000000;
        wait_rises(4 + 34 * 3, 1500);
        check_frame(38, 32'hDEADBEEF, 32'h0123A5F9, "frame2");
        check_frame(72, 32'h00000000, 32'h0123A5F9, "frame3");
        check("fd_first", 64'(fd_cyc[0] - rel), 64'd367);
        check("fd_spacing1", 64'(fd_cyc[1] - fd_cyc[0]), 64'd306);

        // Random words, each loaded mid-frame fr and expected in frame fr+1.
        fr = 4;
        for (int r = 0; r < 3; r++) begin
            wait_rises(4 + 34 * (fr - 1) + 1, 1000);
            w1    = $urandom;
            w2    = $urandom;
            line1 = w1;
            line2 = w2;
            wait_rises(4 + 34 * fr + 34, 1500);
            check_frame(4 + 34 * fr, w1, w2, $sformatf("rnd%0d", r));
            fr += 2;
        end
        check("fd_spacing_last", 64'(fd_cyc[fd_cyc.size()-1] - fd_cyc[fd_cyc.size()-2]),
              64'd306);

        k = 0;
        @(posedge clock);
        #1;
        while (lcd_en !== 1'b1 && k < 100) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("en_before_reset", 64'(lcd_en), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("async_en", 64'(lcd_en), 64'd0);
        check("async_rs", 64'(lcd_rs), 64'd0);
        check("async_data", 64'(lcd_data), 64'd0);
        check("async_ready", 64'(ready), 64'd0);
        check("async_frame_done", 64'(frame_done), 64'd0);
        repeat (3) @(negedge clock);
        clear_log();
        resetn = 1'b1;
        rel    = cyc;
        check_init("init2");
        check("rw_never_high", 64'(rw_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
